// File: rtl/xs3_pkg.sv
// Shared types, constants and helpers for the digit-serial excess-3 adder/subtractor.
package xs3_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StRecomp = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [3:0] XS3_BIAS = 4'd3;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/xs3_serial_addsub_if.sv
// Operand/result handshake bundle between the producer/consumer and the serial adder.
interface xs3_serial_addsub_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4*NUM_DIGITS-1:0]   a_bcd;
    logic [4*NUM_DIGITS-1:0]   b_bcd;
    logic                      mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*NUM_DIGITS-1:0]   result_bcd;
    logic                      carry_out;
    logic                      neg;
    logic                      err;

    modport master (
        output in_valid, a_bcd, b_bcd, mode, out_ready,
        input  in_ready, out_valid, result_bcd, carry_out, neg, err
    );

    modport slave (
        input  in_valid, a_bcd, b_bcd, mode, out_ready,
        output in_ready, out_valid, result_bcd, carry_out, neg, err
    );
endinterface

// File: rtl/xs3_digit_cell.sv
// Single-digit excess-3 adder with decimal correction; invert_b gives the nine's complement of b.
module xs3_digit_cell
    import xs3_pkg::*;
(
    input  logic [3:0] i_xa,
    input  logic [3:0] i_xb,
    input  logic       i_invert_b,
    input  logic       i_cin,
    output logic [3:0] o_xs3,
    output logic       o_cout
);
    logic [3:0] w_xb;
    logic [4:0] w_sum;

    always_comb begin
        w_xb   = i_invert_b ? ~i_xb : i_xb;
        w_sum  = {1'b0, i_xa} + {1'b0, w_xb} + {4'd0, i_cin};
        o_cout = w_sum[4];
        // A carry means the bias was consumed (+3 restores it), otherwise it was doubled (-3).
        o_xs3  = w_sum[4] ? (w_sum[3:0] + XS3_BIAS) : (w_sum[3:0] - XS3_BIAS);
    end
endmodule

// File: rtl/xs3_serial_addsub.sv
// Digit-serial multi-digit BCD add/subtract in excess-3, LSD first, with a recomplement pass
// producing sign-magnitude output when A-B is negative.
module xs3_serial_addsub
    import xs3_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    xs3_serial_addsub_if.slave bus
);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    state_e          r_state, w_state_d;
    logic [IdxW-1:0] r_idx, w_idx_d;
    logic [3:0]      r_xa  [NUM_DIGITS];
    logic [3:0]      w_xa_d[NUM_DIGITS];
    logic [3:0]      r_xb  [NUM_DIGITS];
    logic [3:0]      w_xb_d[NUM_DIGITS];
    logic [3:0]      r_res  [NUM_DIGITS];
    logic [3:0]      w_res_d[NUM_DIGITS];
    logic            r_c, w_c_d;
    logic            r_mode, w_mode_d;
    logic            r_out_valid, w_out_valid_d;
    logic            r_carry_out, w_carry_out_d;
    logic            r_neg, w_neg_d;
    logic            r_err, w_err_d;

    logic            w_in_err;
    logic [3:0]      w_cell_xa, w_cell_xb, w_digit;
    logic            w_cell_inv, w_cout;
    logic [4*NUM_DIGITS-1:0] w_result;

    // Recomplement computes 0 - R: XS3 zero minus the stored first-pass digits.
    always_comb begin
        w_cell_xa  = (r_state == StRecomp) ? XS3_BIAS : r_xa[r_idx];
        w_cell_xb  = (r_state == StRecomp) ? r_xa[r_idx] : r_xb[r_idx];
        w_cell_inv = (r_state == StRecomp) | r_mode;
    end

    xs3_digit_cell u_cell (
        .i_xa       (w_cell_xa),
        .i_xb       (w_cell_xb),
        .i_invert_b (w_cell_inv),
        .i_cin      (r_c),
        .o_xs3      (w_digit),
        .o_cout     (w_cout)
    );

    always_comb begin
        w_in_err = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!bcd_digit_ok(bus.a_bcd[4*i +: 4]) || !bcd_digit_ok(bus.b_bcd[4*i +: 4])) begin
                w_in_err = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_idx_d       = r_idx;
        w_xa_d        = r_xa;
        w_xb_d        = r_xb;
        w_res_d       = r_res;
        w_c_d         = r_c;
        w_mode_d      = r_mode;
        w_out_valid_d = r_out_valid;
        w_carry_out_d = r_carry_out;
        w_neg_d       = r_neg;
        w_err_d       = r_err;

        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_mode_d      = bus.mode;
                    w_c_d         = bus.mode;
                    w_idx_d       = '0;
                    w_carry_out_d = 1'b0;
                    w_neg_d       = 1'b0;
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        w_xa_d[i]  = bus.a_bcd[4*i +: 4] + XS3_BIAS;
                        w_xb_d[i]  = bus.b_bcd[4*i +: 4] + XS3_BIAS;
                        w_res_d[i] = 4'd0;
                    end
                    if (w_in_err) begin
                        w_err_d       = 1'b1;
                        w_out_valid_d = 1'b1;
                        w_state_d     = StDone;
                    end else begin
                        w_state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                w_xa_d[r_idx]  = w_digit;
                w_res_d[r_idx] = w_digit - XS3_BIAS;
                w_c_d          = w_cout;
                w_idx_d        = r_idx + 1'b1;
                if (r_idx == LastIdx) begin
                    w_idx_d = '0;
                    if (!r_mode) begin
                        w_carry_out_d = w_cout;
                        w_out_valid_d = 1'b1;
                        w_state_d     = StDone;
                    end else if (w_cout) begin
                        w_out_valid_d = 1'b1;
                        w_state_d     = StDone;
                    end else begin
                        w_neg_d   = 1'b1;
                        w_c_d     = 1'b1;
                        w_state_d = StRecomp;
                    end
                end
            end
            StRecomp: begin
                w_xa_d[r_idx]  = w_digit;
                w_res_d[r_idx] = w_digit - XS3_BIAS;
                w_c_d          = w_cout;
                w_idx_d        = r_idx + 1'b1;
                if (r_idx == LastIdx) begin
                    w_idx_d       = '0;
                    w_out_valid_d = 1'b1;
                    w_state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_carry_out_d = 1'b0;
                    w_neg_d       = 1'b0;
                    w_err_d       = 1'b0;
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        w_res_d[i] = 4'd0;
                    end
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_c         <= 1'b0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_carry_out <= 1'b0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_xa[i]  <= 4'd0;
                r_xb[i]  <= 4'd0;
                r_res[i] <= 4'd0;
            end
        end else begin
            r_state     <= w_state_d;
            r_idx       <= w_idx_d;
            r_c         <= w_c_d;
            r_mode      <= w_mode_d;
            r_out_valid <= w_out_valid_d;
            r_carry_out <= w_carry_out_d;
            r_neg       <= w_neg_d;
            r_err       <= w_err_d;
            r_xa        <= w_xa_d;
            r_xb        <= w_xb_d;
            r_res       <= w_res_d;
        end
    end

    always_comb begin
        w_result = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_result[4*i +: 4] = r_res[i];
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held, not just after the first edge.
    assign bus.in_ready   = (r_state == StIdle) & rst_n;
    assign bus.out_valid  = r_out_valid;
    assign bus.result_bcd = w_result;
    assign bus.carry_out  = r_carry_out;
    assign bus.neg        = r_neg;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_xs3_serial_addsub.sv
// Directed-vector bench for xs3_serial_addsub with N=4 and hand-computed expectations.
module tb_xs3_serial_addsub;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    xs3_serial_addsub_if #(.NUM_DIGITS(N)) bus ();

    xs3_serial_addsub #(.NUM_DIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_lat counts edges after the accepting edge; an err accept enters DONE on that edge itself.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [15:0] exp_res, input logic exp_cy,
                          input logic exp_neg, input logic exp_err, input int exp_lat,
                          input int hold, input bit poke);
        int lat;
        @(negedge clk);
        check_eq({tag, ".ready_idle"}, {63'd0, bus.in_ready}, 64'd1);
        bus.a_bcd    = a;
        bus.b_bcd    = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = poke;
        bus.a_bcd    = 16'h9999;
        bus.b_bcd    = 16'h8888;
        bus.mode     = ~m;
        check_eq({tag, ".ready_busy"}, {63'd0, bus.in_ready}, 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".result"}, {48'd0, bus.result_bcd}, {48'd0, exp_res});
        check_eq({tag, ".flags"}, {61'd0, bus.carry_out, bus.neg, bus.err},
                 {61'd0, exp_cy, exp_neg, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ".hold"},
                     {45'd0, bus.out_valid, bus.in_ready, bus.result_bcd, bus.carry_out},
                     {45'd0, 1'b1, 1'b0, exp_res, exp_cy});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, ".released"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_bcd     = '0;
        bus.b_bcd     = '0;
        bus.mode      = 1'b0;

        #12;
        check_eq("reset_hold", {57'd0, bus.in_ready, bus.out_valid, bus.carry_out, bus.neg,
                 bus.err, 2'd0}, 64'd0);
        check_eq("reset_result", {48'd0, bus.result_bcd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

        run_op("add_6912", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
        run_op("add_ovf",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0);
        run_op("add_zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
        run_op("sub_pos",  16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
        run_op("sub_neg",  16'h0123, 16'h0500, 1'b1, 16'h0377, 1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
        run_op("sub_eq",   16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
        run_op("sub_m1",   16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
        run_op("err_a",    16'h00A1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        run_op("hold_poke", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 4, 5, 1'b1);

        // Abort a negative subtract while it is recomplementing.
        @(negedge clk);
        bus.a_bcd    = 16'h0123;
        bus.b_bcd    = 16'h0500;
        bus.mode     = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("recomp_neg", {62'd0, bus.neg, bus.out_valid}, 64'd2);
        rst_n = 1'b0;
        #1;
        check_eq("abort_flags", {59'd0, bus.in_ready, bus.out_valid, bus.carry_out, bus.neg,
                 bus.err}, 64'd0);
        check_eq("abort_result", {48'd0, bus.result_bcd}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_out", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
